floor_req_scheduler: RTL and testbench
======================================

# floor_req_scheduler

Collects floor requests from cab/hall buttons into a pending bitmap and issues one target floor at a time to the elevator control unit using SCAN (elevator) ordering. It sits between the button decoder and the control unit's `req` input. It observes the control unit's `floor` and `open` outputs to detect service completion and to clear served requests.

## Interface

Parameters:
- `NUM_FLOORS`, 16 — number of serviceable floors (0 … NUM_FLOORS-1).
- `FLOOR_BITS`, `$clog2(NUM_FLOORS)` — floor index width.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `resetN`  in  1  reset, synchronous and active-low.
- `btn_valid`  in  1  one-cycle request strobe.
- `btn_floor`  in  FLOOR_BITS  requested floor, sampled when `btn_valid`=1.
- `cur_floor`  in  FLOOR_BITS  car position, from the control unit's `floor`.
- `door_open`  in  1  door-open indication, from the control unit's `open`.
- `req`  out  FLOOR_BITS  target floor to the control unit; registered.
- `req_valid`  out  1  1 when in SERVE_UP, SERVE_DOWN or DOOR.
- `pending`  out  NUM_FLOORS  registered request bitmap; bit i = floor i outstanding.
- `dir_up`  out  1  current/last sweep direction; 1=up.
- `err`  out  1  one-cycle pulse on an out-of-range request.
- `btn_cancel`  in  1  cancel strobe; present only with `FLOOR_SCHED_CANCEL_EN`.

## Operation

- **Request capture:**
  - `btn_valid` with `btn_floor` < NUM_FLOORS sets `pending[btn_floor]`; duplicate sets have no effect.
  - `btn_floor` ≥ NUM_FLOORS leaves `pending` unchanged and pulses `err` next cycle.
- **States:** IDLE, SERVE_UP, SERVE_DOWN, DOOR.
- **IDLE:**
  - `req` = `cur_floor`, so the control unit stays put.
  - If `pending` is non-zero, go to SERVE_UP if the nearest pending floor is > `cur_floor`, or SERVE_DOWN if it is < `cur_floor`.
  - Equal distance above and below resolves up.
  - A pending floor equal to `cur_floor` goes to SERVE_UP (dir kept) with `req`=`cur_floor`.
- **SERVE_UP:**
  - Each cycle `req` = lowest pending floor ≥ `cur_floor`. This picks up new requests en route.
  - If none exists (request cancelled), reverse: go to SERVE_DOWN if any pending below, else IDLE.
- **SERVE_DOWN:** mirror of SERVE_UP, using the highest pending floor ≤ `cur_floor`.
- **Arrival:**
  - Condition: in SERVE_* with `door_open`=1 and `cur_floor`==`req`.
  - Action: clear `pending[req]`, go to DOOR, freeze `req`.
- **DOOR:** on `door_open`=0:
  - Continue the same direction if pending floors remain beyond `cur_floor` in that direction.
  - Otherwise reverse (toggle `dir_up`) if any pending remain.
  - Otherwise go to IDLE.
- **Simultaneous events:**
  - A set and the arrival clear on the same floor in the same cycle: clear wins (the request is being served).
  - A press for `req` while in DOOR is ignored.
- **Arithmetic:** all floor comparisons unsigned, FLOOR_BITS wide. No wrap-around; floor 0 and NUM_FLOORS-1 are sweep ends.

## Timing

- **Reset values** (`resetN`=0 at a rising edge):
  - state IDLE
  - `pending`=0, `req`=0, `req_valid`=0, `dir_up`=1, `err`=0
- **Reset mid-operation:** aborts everything. All pending requests are lost.
- **Strobe-to-target latency:**
  - `btn_valid` sampled at edge k → `pending` bit visible after edge k.
  - `req`/`req_valid` reflect it after edge k+1.
- **Arrival latency:**
  - Arrival sampled at edge k → bit cleared and state=DOOR after edge k.
  - `door_open` low sampled at edge m → new `req` after edge m.
- **Hold rule:** `req` never changes while in DOOR.
- **Error pulse:** `err` high for exactly one cycle per offending strobe.

## Configuration

- **`FLOOR_SCHED_CANCEL_EN` defined:**
  - Adds `btn_cancel`. `btn_valid` and `btn_cancel` high together clears `pending[btn_floor]` instead of setting it.
  - Cancel of the floor frozen in DOOR is ignored.
  - Cancel of the current SERVE_* target retargets next cycle, per the SERVE rules.
- **Undefined:** port absent; requests are clearable only by arrival or reset.

## Test plan

Unless noted, NUM_FLOORS=10.

- **Reset:** hold `resetN`=0 for 2 cycles mid-sweep with `pending`≠0 → `pending`=0, `req`=0, `req_valid`=0, `dir_up`=1, IDLE.
- **Basic service:** `cur_floor`=0, press 5 → `pending`=0x020 after 1 edge, `req`=5 and `req_valid`=1 after 2 edges. Drive `cur_floor`=5, `door_open`=1 → `pending`=0, DOOR. Drop `door_open` → IDLE, `req`=5.
- **En-route pickup:** heading up to 7 with `cur_floor`=2, press 4 → `req`=4 next-next cycle. After arrival at 4 and door close → `req`=7.
- **SCAN reversal:** `cur_floor`=5, SERVE_UP, pending {1,8} → serve 8 first. After door close at 8 → `dir_up`=0, `req`=1.
- **Invalid floor:** press 12 → `err`=1 for one cycle, `pending` unchanged, `req` unchanged.
- **Cancel (macro on):** pending {3,6}, SERVE_UP at floor 1, cancel 3 → `pending`={6}, `req`=6. Cancel 6 while in DOOR at 6 → ignored.

Source files
------------

// File: rtl/floor_req_scheduler.sv
// -----------------------------------------------------------------------------
// floor_req_scheduler
//
// Collects floor requests from the button decoder into a pending bitmap and
// hands one target floor at a time to the elevator control unit in SCAN
// (elevator) order. Service completion is detected from the control unit's
// floor/open outputs, which also clear the served request.
//
// Ports:
//   clk        in   system clock, rising edge
//   resetN     in   synchronous active-low reset
//   btn_valid  in   one-cycle request strobe
//   btn_floor  in   requested floor (sampled with btn_valid)
//   cur_floor  in   car position from the control unit
//   door_open  in   door-open indication from the control unit
//   req        out  registered target floor for the control unit
//   req_valid  out  high while a target is being served (SERVE_* / DOOR)
//   pending    out  registered outstanding-request bitmap
//   dir_up     out  current/last sweep direction, 1 = up
//   err        out  one-cycle pulse for an out-of-range request
//   btn_cancel in   cancel strobe (only with FLOOR_SCHED_CANCEL_EN)
//
// Configuration macro: FLOOR_SCHED_CANCEL_EN adds btn_cancel; btn_valid with
// btn_cancel clears pending[btn_floor] instead of setting it.
// -----------------------------------------------------------------------------
module floor_req_scheduler #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_BITS = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  btn_valid,
    input  logic [FLOOR_BITS-1:0] btn_floor,
    input  logic [FLOOR_BITS-1:0] cur_floor,
    input  logic                  door_open,
    output logic [FLOOR_BITS-1:0] req,
    output logic                  req_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  err
`ifdef FLOOR_SCHED_CANCEL_EN
    ,
    input  logic                  btn_cancel
`endif
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_UP   = 2'd1,
        SERVE_DOWN = 2'd2,
        DOOR       = 2'd3
    } state_t;

    // Result of a pending-bitmap search: found flag plus floor index.
    typedef struct packed {
        logic                  found;
        logic [FLOOR_BITS-1:0] idx;
    } hit_t;

    // One extra bit so NUM_FLOORS itself is representable for the range test.
    localparam logic [FLOOR_BITS:0] FLOOR_LIMIT = (FLOOR_BITS+1)'(NUM_FLOORS);

    // Lowest pending floor above f (or at f when incl is set).
    function automatic hit_t find_above(input logic [NUM_FLOORS-1:0] map,
                                        input logic [FLOOR_BITS-1:0] f,
                                        input logic                  incl);
        hit_t h;
        h.found = 1'b0;
        h.idx   = {FLOOR_BITS{1'b0}};
        // Scan downward so the last hit kept is the lowest one.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (map[i] && ((FLOOR_BITS'(i) > f) || (incl && (FLOOR_BITS'(i) == f)))) begin
                h.found = 1'b1;
                h.idx   = FLOOR_BITS'(i);
            end
        end
        return h;
    endfunction

    // Highest pending floor below f (or at f when incl is set).
    function automatic hit_t find_below(input logic [NUM_FLOORS-1:0] map,
                                        input logic [FLOOR_BITS-1:0] f,
                                        input logic                  incl);
        hit_t h;
        h.found = 1'b0;
        h.idx   = {FLOOR_BITS{1'b0}};
        // Scan upward so the last hit kept is the highest one.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (map[i] && ((FLOOR_BITS'(i) < f) || (incl && (FLOOR_BITS'(i) == f)))) begin
                h.found = 1'b1;
                h.idx   = FLOOR_BITS'(i);
            end
        end
        return h;
    endfunction

    // One-hot mask for a floor index; out-of-range indices give all zeros.
    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_BITS-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (FLOOR_BITS'(i) == f);
        end
        return m;
    endfunction

    state_t                state_r;
    logic                  cancel_s;
    logic                  in_range_s;
    logic                  arrive_s;
    logic                  door_hit_s;
    logic                  any_s;
    logic                  choose_up_s;
    logic [FLOOR_BITS-1:0] up_dist_s;
    logic [FLOOR_BITS-1:0] dn_dist_s;
    logic [NUM_FLOORS-1:0] set_mask_s;
    logic [NUM_FLOORS-1:0] clr_mask_s;
    logic [NUM_FLOORS-1:0] pending_nxt_s;
    hit_t                  up_incl_s;
    hit_t                  up_excl_s;
    hit_t                  dn_incl_s;
    hit_t                  dn_excl_s;

`ifdef FLOOR_SCHED_CANCEL_EN
    assign cancel_s = btn_cancel;
`else
    assign cancel_s = 1'b0;
`endif

    // Target search, arrival detection and next pending bitmap.
    always_comb begin
        up_incl_s  = find_above(pending, cur_floor, 1'b1);
        up_excl_s  = find_above(pending, cur_floor, 1'b0);
        dn_incl_s  = find_below(pending, cur_floor, 1'b1);
        dn_excl_s  = find_below(pending, cur_floor, 1'b0);
        any_s      = |pending;
        in_range_s = ({1'b0, btn_floor} < FLOOR_LIMIT);
        arrive_s   = door_open && (cur_floor == req) &&
                     ((state_r == SERVE_UP) || (state_r == SERVE_DOWN));
        // The floor being served with the door open cannot be re-pressed or cancelled.
        door_hit_s = (state_r == DOOR) && (btn_floor == req);

        up_dist_s = up_incl_s.idx - cur_floor;
        dn_dist_s = cur_floor - dn_excl_s.idx;
        // Nearest wins from IDLE; an equal distance resolves upward.
        choose_up_s = up_incl_s.found && (!dn_excl_s.found || (up_dist_s <= dn_dist_s));

        if (btn_valid && in_range_s && !door_hit_s) begin
            if (cancel_s) begin
                set_mask_s = {NUM_FLOORS{1'b0}};
                clr_mask_s = onehot(btn_floor);
            end else begin
                set_mask_s = onehot(btn_floor);
                clr_mask_s = {NUM_FLOORS{1'b0}};
            end
        end else begin
            set_mask_s = {NUM_FLOORS{1'b0}};
            clr_mask_s = {NUM_FLOORS{1'b0}};
        end

        // Clear is applied after set, so an arrival beats a same-floor press.
        if (arrive_s) begin
            pending_nxt_s = (pending | set_mask_s) & ~(clr_mask_s | onehot(req));
        end else begin
            pending_nxt_s = (pending | set_mask_s) & ~clr_mask_s;
        end
    end

    // Scheduler state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r   <= IDLE;
            pending   <= {NUM_FLOORS{1'b0}};
            req       <= {FLOOR_BITS{1'b0}};
            req_valid <= 1'b0;
            dir_up    <= 1'b1;
            err       <= 1'b0;
        end else begin
            pending <= pending_nxt_s;
            err     <= btn_valid && !in_range_s;
            case (state_r)
                IDLE: begin
                    if (!any_s) begin
                        req       <= cur_floor;
                        req_valid <= 1'b0;
                    end else if (choose_up_s) begin
                        state_r   <= SERVE_UP;
                        req       <= up_incl_s.idx;
                        req_valid <= 1'b1;
                        // A request at the current floor keeps the old direction.
                        if (up_incl_s.idx != cur_floor) begin
                            dir_up <= 1'b1;
                        end else begin
                            dir_up <= dir_up;
                        end
                    end else begin
                        state_r   <= SERVE_DOWN;
                        req       <= dn_excl_s.idx;
                        req_valid <= 1'b1;
                        dir_up    <= 1'b0;
                    end
                end
                SERVE_UP: begin
                    if (arrive_s) begin
                        state_r <= DOOR;
                    end else if (up_incl_s.found) begin
                        req <= up_incl_s.idx;
                    end else if (dn_excl_s.found) begin
                        state_r <= SERVE_DOWN;
                        req     <= dn_excl_s.idx;
                        dir_up  <= 1'b0;
                    end else begin
                        state_r   <= IDLE;
                        req       <= cur_floor;
                        req_valid <= 1'b0;
                    end
                end
                SERVE_DOWN: begin
                    if (arrive_s) begin
                        state_r <= DOOR;
                    end else if (dn_incl_s.found) begin
                        req <= dn_incl_s.idx;
                    end else if (up_excl_s.found) begin
                        state_r <= SERVE_UP;
                        req     <= up_excl_s.idx;
                        dir_up  <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        req       <= cur_floor;
                        req_valid <= 1'b0;
                    end
                end
                DOOR: begin
                    // req stays frozen until the door reports closed.
                    if (door_open) begin
                        state_r <= DOOR;
                    end else if (dir_up && up_excl_s.found) begin
                        state_r <= SERVE_UP;
                        req     <= up_excl_s.idx;
                    end else if (!dir_up && dn_excl_s.found) begin
                        state_r <= SERVE_DOWN;
                        req     <= dn_excl_s.idx;
                    end else if (any_s && dir_up) begin
                        state_r <= SERVE_DOWN;
                        req     <= dn_incl_s.idx;
                        dir_up  <= 1'b0;
                    end else if (any_s) begin
                        state_r <= SERVE_UP;
                        req     <= up_incl_s.idx;
                        dir_up  <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        req       <= cur_floor;
                        req_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    req       <= cur_floor;
                    req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floor_req_scheduler.sv
// -----------------------------------------------------------------------------
// tb_floor_req_scheduler
//
// Self-checking bench for floor_req_scheduler with NUM_FLOORS = 10: a table of
// directed vectors, hand-written reset/cancel sequences, then randomized
// stimulus compared against a behavioural model of the scheduling rules.
// -----------------------------------------------------------------------------
module tb_floor_req_scheduler;

    localparam int NF = 10;
    localparam int FB = 4;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    logic          clk = 1'b0;
    logic          resetN;
    logic          btn_valid;
    logic [FB-1:0] btn_floor;
    logic [FB-1:0] cur_floor;
    logic          door_open;
    logic          btn_cancel;
    logic [FB-1:0] req;
    logic          req_valid;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;

    floor_req_scheduler #(.NUM_FLOORS(NF)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .btn_valid (btn_valid),
        .btn_floor (btn_floor),
        .cur_floor (cur_floor),
        .door_open (door_open),
        .req       (req),
        .req_valid (req_valid),
        .pending   (pending),
        .dir_up    (dir_up),
        .err       (err)
`ifdef FLOOR_SCHED_CANCEL_EN
        ,
        .btn_cancel(btn_cancel)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit bv;
        int bf;
        int cf;
        bit dopen;
        int e_req;
        bit e_rv;
        int e_pend;
        bit e_dir;
        bit e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit bv, input int bf, input int cf, input bit dopen,
                           input int e_req, input bit e_rv, input int e_pend,
                           input bit e_dir, input bit e_err);
        vec_t v;
        v.bv = bv; v.bf = bf; v.cf = cf; v.dopen = dopen;
        v.e_req = e_req; v.e_rv = e_rv; v.e_pend = e_pend; v.e_dir = e_dir; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e_req, input bit e_rv,
                             input int e_pend, input bit e_dir, input bit e_err);
        check({tag, ".req"},       int'(req),       e_req);
        check({tag, ".req_valid"}, int'(req_valid), int'(e_rv));
        check({tag, ".pending"},   int'(pending),   e_pend);
        check({tag, ".dir_up"},    int'(dir_up),    int'(e_dir));
        check({tag, ".err"},       int'(err),       int'(e_err));
    endtask

    task automatic drive(input bit bv, input int bf, input int cf, input bit dopen, input bit cancel);
        btn_valid  = bv;
        btn_floor  = FB'(bf);
        cur_floor  = FB'(cf);
        door_open  = dopen;
        btn_cancel = cancel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    bit m_pend[NF];
    int m_mode;
    int m_req;
    bit m_valid;
    bit m_dir;
    bit m_err;

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_mode = M_IDLE; m_req = 0; m_valid = 1'b0; m_dir = 1'b1; m_err = 1'b0;
    endtask

    function automatic int lowest_from(input int f, input bit incl);
        for (int i = 0; i < NF; i++)
            if (m_pend[i] && (i > f || (incl && i == f))) return i;
        return -1;
    endfunction

    function automatic int highest_from(input int f, input bit incl);
        for (int i = NF - 1; i >= 0; i--)
            if (m_pend[i] && (i < f || (incl && i == f))) return i;
        return -1;
    endfunction

    function automatic bit any_pending();
        foreach (m_pend[i]) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pend_word();
        int w = 0;
        foreach (m_pend[i]) if (m_pend[i]) w |= (1 << i);
        return w;
    endfunction

    task automatic go_idle(input int cf);
        m_mode = M_IDLE; m_req = cf;
    endtask

    task automatic model_step(input bit bv, input int bf, input int cf, input bit dopen, input bit cancel);
        bit n_pend[NF];
        bit arrive;
        bit done;
        int a;
        n_pend = m_pend;
        m_err  = bv && (bf >= NF);
        if (bv && bf < NF && !(m_mode == M_DOOR && bf == m_req)) n_pend[bf] = !cancel;
        arrive = (m_mode == M_UP || m_mode == M_DOWN) && dopen && (cf == m_req);
        if (arrive) n_pend[m_req] = 1'b0;
        case (m_mode)
            M_IDLE: begin
                m_req = cf;
                done  = 1'b0;
                // Walk outward from the car; checking above first makes ties go up.
                for (int d = 0; d < NF && !done; d++) begin
                    if (cf + d < NF && m_pend[cf + d]) begin
                        done = 1'b1; m_mode = M_UP; m_req = cf + d;
                        if (d != 0) m_dir = 1'b1;
                    end else if (cf - d >= 0 && m_pend[cf - d]) begin
                        done = 1'b1; m_mode = M_DOWN; m_req = cf - d; m_dir = 1'b0;
                    end
                end
            end
            M_UP: begin
                a = lowest_from(cf, 1'b1);
                if (arrive) m_mode = M_DOOR;
                else if (a >= 0) m_req = a;
                else if (highest_from(cf, 1'b0) >= 0) begin
                    m_mode = M_DOWN; m_dir = 1'b0; m_req = highest_from(cf, 1'b0);
                end else go_idle(cf);
            end
            M_DOWN: begin
                a = highest_from(cf, 1'b1);
                if (arrive) m_mode = M_DOOR;
                else if (a >= 0) m_req = a;
                else if (lowest_from(cf, 1'b0) >= 0) begin
                    m_mode = M_UP; m_dir = 1'b1; m_req = lowest_from(cf, 1'b0);
                end else go_idle(cf);
            end
            default: begin
                if (!dopen) begin
                    if (m_dir && lowest_from(cf, 1'b0) >= 0) begin
                        m_mode = M_UP; m_req = lowest_from(cf, 1'b0);
                    end else if (!m_dir && highest_from(cf, 1'b0) >= 0) begin
                        m_mode = M_DOWN; m_req = highest_from(cf, 1'b0);
                    end else if (any_pending()) begin
                        m_dir = !m_dir;
                        if (m_dir) begin m_mode = M_UP;   m_req = lowest_from(cf, 1'b1);  end
                        else       begin m_mode = M_DOWN; m_req = highest_from(cf, 1'b1); end
                    end else go_idle(cf);
                end
            end
        endcase
        m_pend  = n_pend;
        m_valid = (m_mode != M_IDLE);
    endtask

    initial begin
        int cf;
        int bf;
        bit bv;
        bit dopen;
        bit cancel;

        // Directed scenario: basic service, en-route pickup, SCAN reversal,
        // invalid floor, set/clear collision, press of the door floor.
        //       bv bf cf do   req rv pend   dir err
        add_vec(1, 5, 0, 0,   0, 0, 'h020, 1, 0);
        add_vec(0, 0, 0, 0,   5, 1, 'h020, 1, 0);
        add_vec(0, 0, 3, 0,   5, 1, 'h020, 1, 0);
        add_vec(0, 0, 5, 1,   5, 1, 'h000, 1, 0);
        add_vec(0, 0, 5, 1,   5, 1, 'h000, 1, 0);
        add_vec(0, 0, 5, 0,   5, 0, 'h000, 1, 0);
        add_vec(1, 7, 2, 0,   2, 0, 'h080, 1, 0);
        add_vec(1, 4, 2, 0,   7, 1, 'h090, 1, 0);
        add_vec(0, 0, 2, 0,   4, 1, 'h090, 1, 0);
        add_vec(0, 0, 4, 1,   4, 1, 'h080, 1, 0);
        add_vec(0, 0, 4, 0,   7, 1, 'h080, 1, 0);
        add_vec(1, 1, 5, 0,   7, 1, 'h082, 1, 0);
        add_vec(1, 8, 5, 0,   7, 1, 'h182, 1, 0);
        add_vec(0, 0, 7, 1,   7, 1, 'h102, 1, 0);
        add_vec(0, 0, 7, 0,   8, 1, 'h102, 1, 0);
        add_vec(0, 0, 8, 1,   8, 1, 'h002, 1, 0);
        add_vec(1, 8, 8, 1,   8, 1, 'h002, 1, 0);
        add_vec(0, 0, 8, 0,   1, 1, 'h002, 0, 0);
        add_vec(1, 12, 6, 0,  1, 1, 'h002, 0, 1);
        add_vec(0, 0, 6, 0,   1, 1, 'h002, 0, 0);
        add_vec(1, 1, 1, 1,   1, 1, 'h000, 0, 0);
        add_vec(0, 0, 1, 0,   1, 0, 'h000, 0, 0);
        add_vec(1, 1, 1, 0,   1, 0, 'h002, 0, 0);
        add_vec(0, 0, 1, 0,   1, 1, 'h002, 0, 0);
        add_vec(0, 0, 1, 1,   1, 1, 'h000, 0, 0);
        add_vec(0, 0, 1, 0,   1, 0, 'h000, 0, 0);

        drive(0, 0, 0, 0, 0);
        resetN = 1'b0;
        tick();
        tick();
        check_all("reset0", 0, 0, 'h000, 1, 0);
        resetN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].bv, vecs[i].bf, vecs[i].cf, vecs[i].dopen, 0);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_rv,
                      vecs[i].e_pend, vecs[i].e_dir, vecs[i].e_err);
        end

        // Downward sweep with en-route pickup, then reset mid-sweep.
        drive(1, 2, 8, 0, 0); tick();
        check_all("dn0", 8, 0, 'h004, 0, 0);
        drive(1, 6, 8, 0, 0); tick();
        check_all("dn1", 2, 1, 'h044, 0, 0);
        drive(0, 0, 7, 0, 0); tick();
        check_all("dn2", 6, 1, 'h044, 0, 0);
        resetN = 1'b0;
        tick();
        tick();
        check_all("reset_mid", 0, 0, 'h000, 1, 0);
        resetN = 1'b1;
        drive(0, 0, 4, 0, 0); tick();
        check_all("post_reset", 4, 0, 'h000, 1, 0);

`ifdef FLOOR_SCHED_CANCEL_EN
        drive(1, 3, 1, 0, 0); tick();
        check_all("cxl0", 1, 0, 'h008, 1, 0);
        drive(1, 6, 1, 0, 0); tick();
        check_all("cxl1", 3, 1, 'h048, 1, 0);
        drive(1, 3, 1, 0, 1); tick();
        check_all("cxl2", 3, 1, 'h040, 1, 0);
        drive(0, 0, 1, 0, 0); tick();
        check_all("cxl3", 6, 1, 'h040, 1, 0);
        drive(0, 0, 6, 1, 0); tick();
        check_all("cxl4", 6, 1, 'h000, 1, 0);
        drive(1, 6, 6, 1, 1); tick();
        check_all("cxl5", 6, 1, 'h000, 1, 0);
        drive(0, 0, 6, 0, 0); tick();
        check_all("cxl6", 6, 0, 'h000, 1, 0);
`endif

        // Randomized run against the behavioural model.
        drive(0, 0, 0, 0, 0);
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        model_reset();
        cf = 0;
        for (int c = 0; c < 600; c++) begin
            if ((m_mode == M_UP || m_mode == M_DOWN) && $urandom_range(0, 3) != 0) begin
                if (cf < m_req) cf++;
                else if (cf > m_req) cf--;
            end else if ($urandom_range(0, 24) == 0) begin
                cf = $urandom_range(0, NF - 1);
            end
            if (m_mode == M_DOOR) dopen = ($urandom_range(0, 2) != 0);
            else if (cf == m_req) dopen = ($urandom_range(0, 1) == 1);
            else dopen = ($urandom_range(0, 15) == 0);
            bv = ($urandom_range(0, 2) == 0);
            bf = $urandom_range(0, 15);
`ifdef FLOOR_SCHED_CANCEL_EN
            cancel = bv && ($urandom_range(0, 3) == 0);
`else
            cancel = 1'b0;
`endif
            drive(bv, bf, cf, dopen, cancel);
            model_step(bv, bf, cf, dopen, cancel);
            tick();
            check_all($sformatf("rnd%0d", c), m_req, m_valid, pend_word(), m_dir, m_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
